// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC integer-core icc / Bicc logic:
// flag bit positions, condition encodings, branch FSM states and cc-op decode.
package sparc_pkg;

    localparam int ICC_C = 0;
    localparam int ICC_V = 1;
    localparam int ICC_Z = 2;
    localparam int ICC_N = 3;

    // Base conditions selected by cond[2:0]; cond[3] inverts the base
    localparam logic [2:0] COND_NEVER = 3'b000;
    localparam logic [2:0] COND_E     = 3'b001;
    localparam logic [2:0] COND_LE    = 3'b010;
    localparam logic [2:0] COND_L     = 3'b011;
    localparam logic [2:0] COND_LEU   = 3'b100;
    localparam logic [2:0] COND_CS    = 3'b101;
    localparam logic [2:0] COND_NEG   = 3'b110;
    localparam logic [2:0] COND_VS    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SLOT  = 2'b01,
        ST_ANNUL = 2'b10
    } br_state_e;

    function automatic logic is_cc_op(input logic [5:0] op);
        return (op[5] == 1'b0) && (op[4] == 1'b1);
    endfunction

endpackage

// File: rtl/bicc_eval.sv
// Combinational Bicc condition evaluation against a {N,Z,V,C} flag vector.
module bicc_eval
    import sparc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic base_s;

    // Select the base condition, then apply the inversion bit
    always_comb begin
        base_s = 1'b0;
        case (cond[2:0])
            COND_NEVER: base_s = 1'b0;
            COND_E:     base_s = icc[ICC_Z];
            COND_LE:    base_s = icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]);
            COND_L:     base_s = icc[ICC_N] ^ icc[ICC_V];
            COND_LEU:   base_s = icc[ICC_C] | icc[ICC_Z];
            COND_CS:    base_s = icc[ICC_C];
            COND_NEG:   base_s = icc[ICC_N];
            COND_VS:    base_s = icc[ICC_V];
            default:    base_s = 1'b0;
        endcase
        taken = base_s ^ cond[3];
    end

endmodule

// File: rtl/icc_branch_unit.sv
// icc register with ALU carry feedback, Bicc resolution, target generation
// and delay-slot tracking with annul-driven squash.
module icc_branch_unit
    import sparc_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  alu_op,
    input  logic        n_in,
    input  logic        z_in,
    input  logic        c_in,
    input  logic        v_in,
    input  logic        icc_wr,
    input  logic [3:0]  icc_wdata,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    input  logic        br_annul,
    input  logic [21:0] br_disp22,
    input  logic [31:0] br_pc,
    output logic [3:0]  icc,
    output logic        carry,
    output logic        redirect,
    output logic [31:0] br_target,
    output logic        squash,
    output logic        dcti_err
);

    br_state_e   state_r;
    logic [3:0]  icc_r;
    logic        redirect_r;
    logic [31:0] br_target_r;
    logic        dcti_err_r;

    logic        squash_s;
    logic        cc_wr_s;
    logic [3:0]  icc_next_s;
    logic [3:0]  icc_eval_s;
    logic        taken_s;
    logic        annul_s;
    logic [31:0] target_s;

    assign squash_s   = (state_r == ST_ANNUL) && ex_valid;
    assign cc_wr_s    = ex_valid && is_cc_op(alu_op) && !squash_s;
    assign target_s   = br_pc + {{8{br_disp22[21]}}, br_disp22, 2'b00};

    // Next icc value and the flags the branch evaluator sees this cycle
    always_comb begin
        icc_next_s = icc_r;
        icc_eval_s = icc_r;
        if (icc_wr) begin
            icc_next_s = icc_wdata;
        end else if (cc_wr_s) begin
            icc_next_s = {n_in, z_in, v_in, c_in};
        end else begin
            icc_next_s = icc_r;
        end
        if (BYPASS && (icc_wr || cc_wr_s)) begin
            icc_eval_s = icc_next_s;
        end else begin
            icc_eval_s = icc_r;
        end
    end

    bicc_eval u_bicc_eval (
        .cond  (br_cond),
        .icc   (icc_eval_s),
        .taken (taken_s)
    );

    // BA/BN with a=1 always annul; conditional branches annul only when untaken
    assign annul_s = br_annul && ((br_cond[2:0] == COND_NEVER) || !taken_s);

    // Architectural icc register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc_r <= 4'b0000;
        end else begin
            icc_r <= icc_next_s;
        end
    end

    // Delay-slot FSM with registered redirect, target and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            redirect_r  <= 1'b0;
            br_target_r <= 32'h0000_0000;
            dcti_err_r  <= 1'b0;
        end else begin
            redirect_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (br_valid) begin
                        redirect_r <= taken_s;
                        if (taken_s) begin
                            br_target_r <= target_s;
                        end
                        state_r <= annul_s ? ST_ANNUL : ST_SLOT;
                    end
                end
                ST_SLOT, ST_ANNUL: begin
                    if (br_valid) begin
                        dcti_err_r <= 1'b1;
                    end
                    if (ex_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign icc       = icc_r;
    assign carry     = icc_r[ICC_C];
    assign redirect  = redirect_r;
    assign br_target = br_target_r;
    assign squash    = squash_s;
    assign dcti_err  = dcti_err_r;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Table-driven bench for icc_branch_unit (BYPASS=1) with hand-written
// reset-in-annul and sticky-error sequences.
module tb_icc_branch_unit;

    typedef struct {
        logic        ex;
        logic [5:0]  op;
        logic [3:0]  nzvc;
        logic        wr;
        logic [3:0]  wdata;
        logic        bv;
        logic [3:0]  cond;
        logic        a;
        logic [21:0] disp;
        logic [31:0] pc;
        logic        e_squash;
        logic [3:0]  e_icc;
        logic        e_red;
        logic [31:0] e_tgt;
        logic        e_dcti;
    } vec_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_ADDX  = 6'b001000;
    localparam logic [5:0] OP_ADDCC = 6'b010000;
    localparam logic [5:0] OP_SUBCC = 6'b010100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [5:0]  alu_op;
    logic        n_in, z_in, c_in, v_in;
    logic        icc_wr;
    logic [3:0]  icc_wdata;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_annul;
    logic [21:0] br_disp22;
    logic [31:0] br_pc;
    logic [3:0]  icc;
    logic        carry;
    logic        redirect;
    logic [31:0] br_target;
    logic        squash;
    logic        dcti_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t tbl [24];

    always #5 clk = ~clk;

    icc_branch_unit #(.BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .alu_op    (alu_op),
        .n_in      (n_in),
        .z_in      (z_in),
        .c_in      (c_in),
        .v_in      (v_in),
        .icc_wr    (icc_wr),
        .icc_wdata (icc_wdata),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_annul  (br_annul),
        .br_disp22 (br_disp22),
        .br_pc     (br_pc),
        .icc       (icc),
        .carry     (carry),
        .redirect  (redirect),
        .br_target (br_target),
        .squash    (squash),
        .dcti_err  (dcti_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ex, input logic [5:0] op, input logic [3:0] nzvc,
                                input logic wr, input logic [3:0] wdata,
                                input logic bv, input logic [3:0] cond, input logic a,
                                input logic [21:0] disp, input logic [31:0] pc,
                                input logic esq, input logic [3:0] eicc, input logic ered,
                                input logic [31:0] etgt, input logic edcti);
        vec_t t;
        t.ex = ex; t.op = op; t.nzvc = nzvc; t.wr = wr; t.wdata = wdata;
        t.bv = bv; t.cond = cond; t.a = a; t.disp = disp; t.pc = pc;
        t.e_squash = esq; t.e_icc = eicc; t.e_red = ered; t.e_tgt = etgt; t.e_dcti = edcti;
        return t;
    endfunction

    task automatic drive_idle();
        ex_valid = 1'b0; alu_op = OP_ADD; {n_in, z_in, v_in, c_in} = 4'b0000;
        icc_wr = 1'b0; icc_wdata = 4'b0000; br_valid = 1'b0; br_cond = 4'b0000;
        br_annul = 1'b0; br_disp22 = 22'h0; br_pc = 32'h0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        ex_valid = t.ex; alu_op = t.op; {n_in, z_in, v_in, c_in} = t.nzvc;
        icc_wr = t.wr; icc_wdata = t.wdata; br_valid = t.bv; br_cond = t.cond;
        br_annul = t.a; br_disp22 = t.disp; br_pc = t.pc;
        #1;
        chk($sformatf("v%0d_squash", idx), {31'h0, squash}, {31'h0, t.e_squash});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_icc", idx), {28'h0, icc}, {28'h0, t.e_icc});
        chk($sformatf("v%0d_carry", idx), {31'h0, carry}, {31'h0, t.e_icc[0]});
        chk($sformatf("v%0d_redirect", idx), {31'h0, redirect}, {31'h0, t.e_red});
        chk($sformatf("v%0d_target", idx), br_target, t.e_tgt);
        chk($sformatf("v%0d_dcti", idx), {31'h0, dcti_err}, {31'h0, t.e_dcti});
    endtask

    initial begin
        //               ex    op        nzvc     wr    wdata    bv    cond     a     disp        pc             sq    icc      red   target         dcti
        tbl[0]  = mk(1'b1, OP_SUBCC, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 22'h000003, 32'h0000_0100, 1'b0, 4'b0100, 1'b1, 32'h0000_010C, 1'b0);
        tbl[1]  = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0100, 1'b0, 32'h0000_010C, 1'b0);
        tbl[2]  = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1001, 1'b1, 22'h000010, 32'h0000_0200, 1'b0, 4'b0100, 1'b0, 32'h0000_010C, 1'b0);
        tbl[3]  = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0100, 1'b0, 32'h0000_010C, 1'b0);
        tbl[4]  = mk(1'b1, OP_ADDCC, 4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b1, 4'b0100, 1'b0, 32'h0000_010C, 1'b0);
        tbl[5]  = mk(1'b1, OP_ADDCC, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0001, 1'b0, 32'h0000_010C, 1'b0);
        tbl[6]  = mk(1'b1, OP_ADDX,  4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0001, 1'b0, 32'h0000_010C, 1'b0);
        tbl[7]  = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 22'h3FFFFE, 32'h0000_0004, 1'b0, 4'b0001, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tbl[8]  = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b1, 4'b0001, 1'b0, 32'hFFFF_FFFC, 1'b0);
        tbl[9]  = mk(1'b1, OP_ADDCC, 4'b0000, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b1001, 1'b0, 32'hFFFF_FFFC, 1'b0);
        tbl[10] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 22'h000005, 32'h0000_0300, 1'b0, 4'b1001, 1'b0, 32'hFFFF_FFFC, 1'b0);
        tbl[11] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 22'h000001, 32'h0000_0200, 1'b0, 4'b1001, 1'b0, 32'hFFFF_FFFC, 1'b1);
        tbl[12] = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b1001, 1'b0, 32'hFFFF_FFFC, 1'b1);
        tbl[13] = mk(1'b0, OP_ADD,   4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0011, 1'b1, 22'h200000, 32'h0000_1000, 1'b0, 4'b1000, 1'b1, 32'hFF80_1000, 1'b1);
        tbl[14] = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b1000, 1'b0, 32'hFF80_1000, 1'b1);
        tbl[15] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1100, 1'b1, 22'h000000, 32'h0000_0040, 1'b0, 4'b1000, 1'b1, 32'h0000_0040, 1'b1);
        tbl[16] = mk(1'b1, OP_ADDCC, 4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0110, 1'b0, 32'h0000_0040, 1'b1);
        // After the mid-ANNUL reset: first instruction must not be squashed
        tbl[17] = mk(1'b1, OP_ADDCC, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 32'h0000_0000, 1'b0);
        tbl[18] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 22'h000002, 32'h0000_0010, 1'b0, 4'b0010, 1'b1, 32'h0000_0018, 1'b0);
        tbl[19] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 22'h000007, 32'h0000_0400, 1'b0, 4'b0010, 1'b0, 32'h0000_0018, 1'b1);
        tbl[20] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 32'h0000_0018, 1'b1);
        tbl[21] = mk(1'b0, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 32'h0000_0018, 1'b1);
        tbl[22] = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 32'h0000_0018, 1'b1);
        tbl[23] = mk(1'b1, OP_ADD,   4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 22'h000000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 32'h0000_0018, 1'b1);

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_icc", {28'h0, icc}, 32'h0);
        chk("rst_carry", {31'h0, carry}, 32'h0);
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk("rst_target", br_target, 32'h0);
        chk("rst_squash", {31'h0, squash}, 32'h0);
        chk("rst_dcti", {31'h0, dcti_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], i);
        end

        // Enter ANNUL with BA,a=1 (no ex_valid), then reset asynchronously
        run_vec(mk(1'b0, OP_ADD, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 22'h000001,
                   32'h0000_0020, 1'b0, 4'b0110, 1'b1, 32'h0000_0024, 1'b1), 100);
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_icc", {28'h0, icc}, 32'h0);
        chk("midrst_dcti", {31'h0, dcti_err}, 32'h0);
        chk("midrst_target", br_target, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 17; i < 24; i++) begin
            run_vec(tbl[i], i);
        end

        drive_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/icc_branch_unit.md
# icc_branch_unit

Integer-condition-code and delayed-branch unit for the SPARC integer core. Sits directly downstream of the ALU: it latches the N/Z/C/V flags produced by cc-modifying operations into the architectural icc register and feeds the registered carry back to the ALU for addx/subx. It also resolves Bicc branches against the current icc, generates the branch target, and tracks the delay slot, squashing the slot instruction when the annul rules require it.

## Interface
- `BYPASS`, 1: 1 = branch evaluation sees flags written in the same cycle; 0 = registered icc only.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: an instruction is in the ALU stage this cycle.
- `alu_op` in 6: ALU operation code of that instruction.
- `n_in`, `z_in`, `c_in`, `v_in` in 1 each: ALU flag outputs.
- `icc_wr` in 1: direct icc write (wr psr).
- `icc_wdata` in 4: {N,Z,V,C} for direct write.
- `br_valid` in 1: Bicc presented this cycle.
- `br_cond` in 4: Bicc cond field.
- `br_annul` in 1: Bicc a bit.
- `br_disp22` in 22: word displacement.
- `br_pc` in 32: PC of the branch.
- `icc` out 4: {N,Z,V,C} register.
- `carry` out 1: `icc[0]`, registered; to ALU carry input.
- `redirect` out 1: one-cycle pulse, branch taken.
- `br_target` out 32: registered target, valid with `redirect`.
- `squash` out 1: current `ex_valid` instruction is annulled.
- `dcti_err` out 1: sticky; branch seen while delay slot pending.

## Operation
- cc-op decode: `alu_op[5]==0 && alu_op[4]==1`. cc write when `ex_valid && cc-op && !squash`.
- icc update priority: `icc_wr` > cc write > hold. Flags packed {n_in,z_in,v_in,c_in}.
- Effective icc for evaluation: with `BYPASS=1` and a cc write or `icc_wr` this cycle, the incoming value; else the register.
- Condition: `br_cond[2:0]` selects base: 000 false, 001 Z, 010 Z|(N^V), 011 N^V, 100 C|Z, 101 C, 110 N, 111 V. `br_cond[3]` inverts base (1000 = BA, 0000 = BN).
- Target: `br_pc + sext(br_disp22) << 2`, 32-bit, modulo 2^32.
- Annul: a=0 → slot always executes. a=1: conditional taken → executes; conditional untaken → annulled; BA or BN → annulled.
- FSM states: IDLE, SLOT (slot executes), ANNUL (slot squashed).
  - IDLE & `br_valid`: → ANNUL if annulled, else → SLOT.
  - SLOT & `ex_valid`: → IDLE.
  - ANNUL & `ex_valid`: `squash`=1 combinationally, cc write suppressed, → IDLE.
  - `br_valid` in SLOT/ANNUL: ignored, `dcti_err` set; state advances per `ex_valid` as normal.
- `squash` = `state==ANNUL && ex_valid`; never asserted otherwise.

## Timing
- Reset values: `icc`=0, `carry`=0, `redirect`=0, `br_target`=0, `squash`=0, `dcti_err`=0, state IDLE.
- Reset mid-operation: immediate return to IDLE; pending annul discarded; no squash follows.
- icc/carry latency: 1 cycle after the cc-op's `ex_valid` cycle; addcc followed by addx in the next cycle sees the new carry.
- Branch: evaluated in the `br_valid` cycle; `redirect`/`br_target` valid the following cycle for exactly one cycle.
- `br_valid` and `ex_valid` may coincide: the cc write and branch evaluation occur in the same cycle (bypass per `BYPASS`).
- Slot waits indefinitely for `ex_valid`; stall cycles hold state.

## Structure
- Shared package `sparc_pkg`: icc bit indices (C=0, V=1, Z=2, N=3), Bicc cond encodings, FSM state enum, cc-op decode function.
- Sub-module `bicc_eval`: combinational cond + icc → taken.
- Top: icc register, FSM, target adder, output registers.

## Test plan
- `ex_valid`, subcc flags Z=1, with BE a=0 (br_pc=0x100, disp=3) in the same cycle, `BYPASS=1` → next cycle `icc`=4'b0100, `redirect`=1, `br_target`=0x10C; state SLOT, then IDLE on the next `ex_valid`.
- BNE a=1 with Z=1 → no redirect; next `ex_valid` addcc → `squash`=1 and `icc` unchanged.
- BA a=1, br_pc=0x4, disp=-2 → `br_target`=0xFFFFFFFC, `redirect`=1, delay slot squashed.
- addcc with c_in=1, then addx `ex_valid` next cycle → `carry`=1 during addx.
- `icc_wr`=1 with `icc_wdata`=4'b1001 and a cc-op with flags 0000 in the same cycle → `icc`=4'b1001.
- `rst_n` low while in ANNUL → state IDLE, `icc`=0; next `ex_valid` `squash`=0. Second branch in SLOT → `dcti_err`=1 and it stays set.
